// File: rtl/record_serializer_pkg.sv
// -----------------------------------------------------------------------------
// parser_pkg
// Shared constants and types for the parser back end.
//   REC_W     : parsed record width in bits (a multiple of 8)
//   WORD_W    : serialized output word width in bits
//   NWORDS    : output words per record
//   LAST_KEEP : byte-keep mask of the final word of a record
//   state_e   : serializer state (IDLE = nothing held, SEND = record held)
// -----------------------------------------------------------------------------
package parser_pkg;

  localparam int REC_W      = 296;
  localparam int WORD_W     = 32;
  localparam int KEEP_W     = WORD_W / 8;
  localparam int NWORDS     = (REC_W + WORD_W - 1) / WORD_W;
  localparam int LAST_BYTES = (REC_W - (NWORDS - 1) * WORD_W) / 8;

  // Valid bytes of the final word sit at the top of the word, so the mask
  // is a run of ones starting from the MSB.
  localparam logic [KEEP_W-1:0] LAST_KEEP = ~({KEEP_W{1'b1}} >> LAST_BYTES);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/record_serializer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value.
//   clk     : clock
//   reset_b : asynchronous active-low reset, clears the count
//   inc     : count one on this rising edge
//   clr     : synchronous clear (wins over inc)
//   count   : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/record_serializer.sv
// -----------------------------------------------------------------------------
// record_serializer
// Takes one parsed record per handshake and emits it as a framed stream of
// WORD_W-bit words (last + byte keep). Also counts lost-packet cycles
// (saturating) and fully serialized records (wrapping).
//   clk           : clock
//   reset_b       : asynchronous active-low reset
//   dataIn        : record, bit 0 = MSB of record byte 0
//   dataIn_val    : record valid
//   dataIn_ready  : record accepted when valid && ready at a clock edge
//   packetLost    : lost-packet indication, sampled every cycle
//   dataOut       : serialized word
//   dataOut_val   : word valid
//   dataOut_ready : downstream accepts the word
//   dataOut_last  : final word of a record
//   dataOut_keep  : byte-valid mask, MSB = dataOut top byte
//   lostCount     : saturating count of packetLost cycles
//   recCount      : wrapping count of records fully serialized
// -----------------------------------------------------------------------------
module record_serializer
  import parser_pkg::*;
#(
  parameter int REC_W  = 296,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic [0:REC_W-1]      dataIn,
  input  logic                  dataIn_val,
  output logic                  dataIn_ready,
  input  logic                  packetLost,
  output logic [WORD_W-1:0]     dataOut,
  output logic                  dataOut_val,
  input  logic                  dataOut_ready,
  output logic                  dataOut_last,
  output logic [WORD_W/8-1:0]   dataOut_keep,
  output logic [CNT_W-1:0]      lostCount,
  output logic [CNT_W-1:0]      recCount
);

  localparam int NW         = (REC_W + WORD_W - 1) / WORD_W;
  localparam int PAD_W      = NW * WORD_W;
  localparam int KW         = WORD_W / 8;
  localparam int IDX_W      = (NW > 1) ? $clog2(NW) : 1;
  localparam int LST_BYTES  = (REC_W - (NW - 1) * WORD_W) / 8;
  localparam logic [KW-1:0]    L_LAST_KEEP = ~({KW{1'b1}} >> LST_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NW - 1);

  state_e              r_state;
  state_e              w_state_next;
  logic [0:PAD_W-1]    r_shift;
  logic [0:PAD_W-1]    w_load_vec;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_rec_cnt;
  logic                r_run;
  logic                w_ready;
  logic                w_val;
  logic                w_at_last;
  logic                w_in_hs;
  logic                w_out_hs;
  logic [WORD_W-1:0]   w_word;
  logic                w_lost_inc;

  assign w_at_last = (r_idx == LAST_IDX);

  // The record is left-aligned in a word-multiple shift register so the
  // trailing pad bits of the last word come out as zero.
  assign w_load_vec = PAD_W'(dataIn) << (PAD_W - REC_W);

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_val        = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (dataIn_val) begin
          w_state_next = SEND;
        end
      end
      SEND: begin
        w_val = 1'b1;
        // A new record may be taken in the cycle the last word leaves,
        // which gives bubble-free back-to-back records.
        w_ready = w_at_last && dataOut_ready;
        if (w_at_last && dataOut_ready && !dataIn_val) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_in_hs  = dataIn_val && w_ready;
  assign w_out_hs = w_val && dataOut_ready;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_idx     <= '0;
      r_rec_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_in_hs) begin
        r_shift <= w_load_vec;
        r_idx   <= '0;
      end else if (w_out_hs) begin
        r_shift <= r_shift << WORD_W;
        r_idx   <= w_at_last ? '0 : r_idx + IDX_W'(1);
      end
      if (w_out_hs && w_at_last) begin
        r_rec_cnt <= r_rec_cnt + CNT_W'(1);
      end
    end
  end

  // r_run is low on the first edge after reset release so a packetLost
  // pulse coincident with that edge is not counted.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  assign w_lost_inc = packetLost && r_run;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_lost_cnt (
    .clk     (clk),
    .reset_b (reset_b),
    .inc     (w_lost_inc),
    .clr     (1'b0),
    .count   (lostCount)
  );

  // Shift-register bit 0 is the oldest record bit and maps to the word MSB.
  for (genvar gi = 0; gi < WORD_W; gi++) begin : g_word_bits
    assign w_word[WORD_W-1-gi] = r_shift[gi];
  end

  assign dataIn_ready = w_ready;
  assign dataOut_val  = w_val;
  assign dataOut      = w_val ? w_word : '0;
  assign dataOut_last = w_val && w_at_last;
  assign dataOut_keep = w_val ? (w_at_last ? L_LAST_KEEP : {KW{1'b1}}) : '0;
  assign recCount     = r_rec_cnt;

endmodule

// File: tb/tb_record_serializer.sv
module tb_record_serializer;

  localparam int REC_W  = 296;
  localparam int WORD_W = 32;
  localparam int CW     = 8;
  localparam int NBYTES = REC_W / 8;
  localparam int NW     = (REC_W + WORD_W - 1) / WORD_W;
  localparam int CMAX   = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset_b = 1'b0;
  logic [0:REC_W-1]  dataIn;
  logic              dataIn_val;
  logic              dataIn_ready;
  logic              packetLost;
  logic [31:0]       dataOut;
  logic              dataOut_val;
  logic              dataOut_ready;
  logic              dataOut_last;
  logic [3:0]        dataOut_keep;
  logic [CW-1:0]     lostCount;
  logic [CW-1:0]     recCount;

  record_serializer #(
    .REC_W  (REC_W),
    .WORD_W (WORD_W),
    .CNT_W  (CW)
  ) dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .dataIn        (dataIn),
    .dataIn_val    (dataIn_val),
    .dataIn_ready  (dataIn_ready),
    .packetLost    (packetLost),
    .dataOut       (dataOut),
    .dataOut_val   (dataOut_val),
    .dataOut_ready (dataOut_ready),
    .dataOut_last  (dataOut_last),
    .dataOut_keep  (dataOut_keep),
    .lostCount     (lostCount),
    .recCount      (recCount)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [31:0] w;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  exp_t             expq[$];
  logic [0:REC_W-1] pend[$];
  logic [0:REC_W-1] r;

  int   checks = 0;
  int   errors = 0;
  int   exp_rec = 0;
  int   exp_lost = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   last_cyc = 0;
  int   n_accept = 0;
  int   rdy_in_send = 0;
  int   bubbles = 0;
  int   val_cycles = 0;
  int   total_words = 0;
  bit   lost_hold = 1'b0;
  bit   prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic [3:0]  prev_k;
  logic        prev_l;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [0:REC_W-1] rand_rec();
    logic [0:REC_W-1] v;
    v = '0;
    for (int j = 0; j < NBYTES; j++) v[8*j +: 8] = 8'($urandom);
    return v;
  endfunction

  // Reference model: byte j of the record goes to word j/4, byte lane j%4
  // counted from the top; missing bytes are zero and not kept.
  task automatic push_words(input logic [0:REC_W-1] rec);
    exp_t e;
    logic [7:0] bt;
    for (int k = 0; k < NW; k++) begin
      e = '0;
      for (int b = 0; b < 4; b++) begin
        int j;
        j = 4 * k + b;
        bt = (j < NBYTES) ? rec[8*j +: 8] : 8'h00;
        e.w = {e.w[23:0], bt};
        e.k[3-b] = (j < NBYTES);
      end
      e.l = (k == NW - 1);
      expq.push_back(e);
    end
  endtask

  task automatic step(input bit rnd_rdy, input bit rnd_val, input bit rnd_lost);
    exp_t e;
    @(negedge clk);
    dataOut_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pend.size() > 0 && (!rnd_val || $urandom_range(0, 3) != 0)) begin
      dataIn_val = 1'b1;
      dataIn     = pend[0];
    end else begin
      dataIn_val = 1'b0;
      dataIn     = rand_rec();
    end
    packetLost = rnd_lost ? 1'($urandom_range(0, 1)) : lost_hold;
    #1;
    cyc++;
    chk("recCount", recCount, exp_rec % (CMAX + 1));
    chk("lostCount", lostCount, (exp_lost > CMAX) ? CMAX : exp_lost);
    if (prev_stall) begin
      chk("stall_val", dataOut_val, 1);
      chk("stall_data", dataOut, prev_d);
      chk("stall_keep", dataOut_keep, prev_k);
      chk("stall_last", dataOut_last, prev_l);
    end
    if (expq.size() > 0 && !dataOut_val) bubbles++;
    if (dataOut_val) val_cycles++;
    if (dataOut_val && dataOut_ready) begin
      if (expq.size() == 0) begin
        chk("spurious_val", dataOut_val, 0);
      end else begin
        e = expq.pop_front();
        chk("word", dataOut, e.w);
        chk("keep", dataOut_keep, e.k);
        chk("last", dataOut_last, e.l);
        total_words++;
        if (e.l) begin
          exp_rec++;
          last_cyc = cyc;
        end
      end
    end
    if (dataIn_val && dataIn_ready) begin
      n_accept++;
      accept_cyc = cyc;
      if (dataOut_val) rdy_in_send++;
      push_words(pend.pop_front());
    end
    if (packetLost) exp_lost++;
    prev_stall = dataOut_val && !dataOut_ready;
    prev_d = dataOut;
    prev_k = dataOut_keep;
    prev_l = dataOut_last;
  endtask

  task automatic drain(input bit rr, input bit rv, input bit rl, input int maxc);
    int n;
    n = 0;
    while ((pend.size() > 0 || expq.size() > 0) && n < maxc) begin
      step(rr, rv, rl);
      n++;
    end
    chk("drain_outstanding", pend.size() + expq.size(), 0);
  endtask

  initial begin
    int w0;
    int n;
    dataIn        = '0;
    dataIn_val    = 1'b0;
    dataOut_ready = 1'b0;
    packetLost    = 1'b0;

    // Reset state
    #5;
    chk("rst_val", dataOut_val, 0);
    chk("rst_data", dataOut, 0);
    chk("rst_keep", dataOut_keep, 0);
    chk("rst_last", dataOut_last, 0);
    chk("rst_lost", lostCount, 0);
    chk("rst_rec", recCount, 0);
    @(negedge clk);
    #3 reset_b = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst", dataIn_ready, 1);

    // Single record with bytes 0x00..0x24, no stalls
    r = '0;
    for (int j = 0; j < NBYTES; j++) r[8*j +: 8] = 8'(j);
    pend.push_back(r);
    drain(1'b0, 1'b0, 1'b0, 40);
    chk("latency", last_cyc - accept_cyc, NW);
    @(posedge clk);
    #1 chk("rec_after_one", recCount, 1);

    // Two records back-to-back with valid held high
    n_accept = 0; rdy_in_send = 0; bubbles = 0; val_cycles = 0;
    pend.push_back(rand_rec());
    pend.push_back(rand_rec());
    drain(1'b0, 1'b0, 1'b0, 60);
    chk("b2b_accepts", n_accept, 2);
    chk("b2b_ready_in_send", rdy_in_send, 1);
    chk("b2b_bubbles", bubbles, 0);
    chk("b2b_val_cycles", val_cycles, 2 * NW);

    // Random stalls, random valid gaps, random packetLost
    bubbles = 0;
    for (int i = 0; i < 20; i++) pend.push_back(rand_rec());
    drain(1'b1, 1'b1, 1'b1, 3000);
    chk("stall_bubbles", bubbles, 0);

    // packetLost held long enough to saturate the counter
    lost_hold = 1'b1;
    for (int i = 0; i < CMAX + 45; i++) step(1'b0, 1'b0, 1'b0);
    lost_hold = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("lost_saturated", lostCount, CMAX);

    // Reset during word 4 of a record
    pend.push_back(rand_rec());
    w0 = total_words;
    n = 0;
    while (total_words - w0 < 4 && n < 20) begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("reached_word4", total_words - w0, 4);
    @(posedge clk);
    #2;
    chk("word4_val", dataOut_val, 1);
    chk("word4_data", dataOut, expq[0].w);
    reset_b = 1'b0;
    #1;
    chk("midrst_val", dataOut_val, 0);
    chk("midrst_data", dataOut, 0);
    chk("midrst_keep", dataOut_keep, 0);
    chk("midrst_last", dataOut_last, 0);
    chk("midrst_rec", recCount, 0);
    chk("midrst_lost", lostCount, 0);
    expq.delete();
    pend.delete();
    exp_rec = 0;
    exp_lost = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    #3 reset_b = 1'b1;
    pend.push_back(rand_rec());
    drain(1'b0, 1'b0, 1'b0, 40);

    // Fill up to 2^CW records in total: recCount wraps to 0
    for (int i = 0; i < CMAX; i++) pend.push_back(rand_rec());
    drain(1'b0, 1'b0, 1'b0, 12 * (CMAX + 1));
    @(posedge clk);
    #1 chk("rec_wrap", recCount, exp_rec % (CMAX + 1));
    chk("rec_wrap_zero", recCount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/record_serializer.md
# record_serializer

Downstream stage of the sequence parser. Accepts one 296-bit parsed record per handshake and re-emits it as a framed stream of 32-bit words with last and byte-keep, so records can travel over the 32-bit fabric. Also keeps a saturating count of the parser's lost-packet indications and a wrapping count of serialized records for status readout.

## Interface

Parameters:
- REC_W, 296, record width in bits; must be a multiple of 8.
- WORD_W, 32, output word width in bits.
- CNT_W, 16, width of both status counters.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_b  in  1  reset, asynchronous assert, active-low.
- dataIn  in  [0:REC_W-1]  record from the parser; bit 0 is the MSB of record byte 0.
- dataIn_val  in  1  record valid.
- dataIn_ready  out  1  record accepted when dataIn_val && dataIn_ready at a clk edge.
- packetLost  in  1  lost-packet indication from the parser; sampled every cycle.
- dataOut  out  [WORD_W-1:0]  serialized word.
- dataOut_val  out  1  word valid.
- dataOut_ready  in  1  downstream accepts the word when dataOut_val && dataOut_ready.
- dataOut_last  out  1  high on the final word of a record.
- dataOut_keep  out  [WORD_W/8-1:0]  byte-valid mask; bit 3 = dataOut[31:24].
- lostCount  out  [CNT_W-1:0]  saturating count of cycles with packetLost=1.
- recCount  out  [CNT_W-1:0]  wrapping count of records fully serialized.

## Operation

- NWORDS = ceil(REC_W/WORD_W) = 10; the final word carries REC_W - 9*WORD_W = 8 valid bits.
- Word k (k=0..NWORDS-1): dataOut[31] = record bit 32k, dataOut[31-i] = record bit 32k+i. Bits past REC_W-1 drive 0.
- dataOut_keep = 4'b1111 for words 0..8; LAST_KEEP = 4'b1000 for word 9. dataOut_last=1 only on word 9.
- State machine: IDLE (no record held) and SEND (record held in holding register, word index idx).
  - IDLE: dataIn_ready=1, dataOut_val=0. On input handshake: capture dataIn, idx=0, go SEND.
  - SEND: dataOut_val=1. On output handshake with idx<NWORDS-1: idx+1. On output handshake with idx=NWORDS-1: recCount+1 (wraps); if an input handshake occurs in the same cycle, capture the new record, idx=0, stay SEND; otherwise go IDLE.
- dataIn_ready = (state==IDLE) || (state==SEND && idx==NWORDS-1 && dataOut_ready); combinational path from dataOut_ready to dataIn_ready is intended.
- lostCount increments on every clk edge with packetLost=1, holds at 2^CNT_W-1. Independent of the state machine.
- dataIn content is ignored when dataIn_val=0.

## Timing

- Reset (reset_b=0, immediate): state=IDLE, idx=0, holding register=0, lostCount=0, recCount=0; dataOut_val=0, dataOut_last=0, dataOut_keep=0, dataOut=0. dataIn_ready=1 from the first cycle after reset release.
- Latency: record accepted at edge T → word 0 valid after T; with dataOut_ready held 1, word 9 transfers at edge T+10.
- Throughput: back-to-back records with no bubble; one record per 10 cycles at full rate.
- Stall: while dataOut_val=1 and dataOut_ready=0, dataOut, dataOut_keep, dataOut_last and idx hold.
- Reset asserted mid-record: record discarded, no partial last emitted, counters cleared.
- packetLost coincident with reset release edge is not counted.

## Structure

- Package parser_pkg: REC_W, WORD_W, NWORDS, LAST_KEEP constants and the state enum {IDLE, SEND}.
- One sub-module, sat_counter (parameter CNT_W, inputs inc and clr), used for lostCount; recCount is a plain wrapping counter inside the top.

## Test plan

- Single record, bytes 0x00..0x24, dataOut_ready=1 → words 0x00010203 … 0x20212223, then 0x24000000 with keep=4'b1000, last=1; recCount=1.
- Two records back-to-back, dataIn_val held 1 → 20 consecutive valid words, no idle cycle between word 9 and word 0; dataIn_ready high exactly on the two accept cycles.
- dataOut_ready toggling every 15 ns against a 20 ns clock → word sequence identical to the unstalled case, outputs stable during every stall.
- packetLost held 1 for 70000 cycles → lostCount saturates at 0xFFFF; recCount unchanged.
- reset_b pulsed low during word 4 → all outputs 0 immediately; next record starts at word 0; recCount=0.
- 65536 records serialized → recCount wraps to 0.
